// File: rtl/seven_seg_scroller.sv
// seven_seg_scroller: display stage for the signed multiplier datapath.
// Captures a 5-digit BCD magnitude plus sign into a 6-character buffer and
// time-multiplexes a 4-digit active-low seven-segment display. Scroll
// pulses slide the 4-character window across the 6 characters.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   load         single-cycle pulse, captures bcd and sign
//   bcd[19:0]    five BCD nibbles, [3:0] = units
//   sign         1 = negative product
//   scroll_left  pulse, window moves towards more-significant characters
//   scroll_right pulse, window moves towards less-significant characters
//   an[3:0]      digit enables, active-low, an[0] = rightmost digit
//   seg[6:0]     {g,f,e,d,c,b,a}, active-low
module seven_seg_scroller #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [19:0] bcd,
    input  logic        sign,
    input  logic        scroll_left,
    input  logic        scroll_right,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned NCHAR   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [1:0] OFF_MAX   = 2'd2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       off_q, off_d;
    logic [19:0]      bcd_q, bcd_d;
    logic             sign_q, sign_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic [6:0]       char_seg [NCHAR];
    logic [4:0]       sig;
    logic [2:0]       idx;

    // Digit glyphs; anything above 9 renders blank.
    function automatic logic [6:0] encode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Character buffer with leading-zero blanking. sig[k] is set when some
    // nibble at k or above is a valid nonzero digit; invalid nibbles never count.
    always_comb begin
        sig = '0;
        for (int k = 4; k >= 0; k--) begin
            logic [3:0] n;
            n = bcd_q[4*k +: 4];
            sig[k] = ((n != 4'd0) && (n <= 4'd9)) || ((k < 4) ? sig[k+1] : 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            if ((k != 0) && !sig[k]) char_seg[k] = SEG_BLANK;
            else                     char_seg[k] = encode(bcd_q[4*k +: 4]);
        end
        char_seg[5] = sign_q ? SEG_DASH : SEG_BLANK;
    end

    // Next-state and registered-output logic.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        sel_d  = sel_q;
        off_d  = off_q;
        bcd_d  = bcd_q;
        sign_d = sign_q;
        an_d   = ~(4'b0001 << sel_q);
        seg_d  = SEG_BLANK;

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
        end

        // Simultaneous left/right cancels out.
        if (scroll_left && !scroll_right && (off_q != OFF_MAX))
            off_d = off_q + 2'd1;
        else if (scroll_right && !scroll_left && (off_q != 2'd0))
            off_d = off_q - 2'd1;

        if (load) begin
            bcd_d  = bcd;
            sign_d = sign;
        end

        idx = 3'(off_q) + 3'(sel_q);
        case (idx)
            3'd0:    seg_d = char_seg[0];
            3'd1:    seg_d = char_seg[1];
            3'd2:    seg_d = char_seg[2];
            3'd3:    seg_d = char_seg[3];
            3'd4:    seg_d = char_seg[4];
            3'd5:    seg_d = char_seg[5];
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            off_q  <= '0;
            bcd_q  <= '0;
            sign_q <= 1'b0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            off_q  <= off_d;
            bcd_q  <= bcd_d;
            sign_q <= sign_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_scroller.sv
module tb_seven_seg_scroller;

    localparam int unsigned DIV = 4;
    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_DA = 7'b0111111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [19:0] bcd = '0;
    logic        sign = 1'b0;
    logic        scroll_left = 1'b0;
    logic        scroll_right = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_pass = 0;
    int n_total = 0;

    logic [6:0]  glyph [10];
    logic [10:0] sb_q [$];
    logic [10:0] exp_v;
    logic [6:0]  fr   [4];
    logic [6:0]  want [4];

    int         m_cnt;
    logic [1:0] m_sel, m_off;
    logic [19:0] m_bcd;
    logic       m_sign;

    seven_seg_scroller #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd(bcd), .sign(sign),
        .scroll_left(scroll_left), .scroll_right(scroll_right),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
    end

    // Expected {an,seg}: find the most significant valid nonzero nibble,
    // anything above it (and any invalid nibble) is blank.
    function automatic logic [10:0] model_out(input logic [1:0] s, input logic [1:0] o,
                                              input logic [19:0] b, input logic sg);
        int h;
        int c;
        logic [3:0] n;
        logic [6:0] sv;
        h = 0;
        for (int k = 1; k <= 4; k++) begin
            n = b[4*k +: 4];
            if (n != 0 && n <= 9) h = k;
        end
        c = int'(o) + int'(s);
        if (c == 5) sv = sg ? S_DA : S_BL;
        else begin
            n = b[4*c +: 4];
            if (c > h || n > 9) sv = S_BL;
            else sv = glyph[n];
        end
        return {~(4'b0001 << s), sv};
    endfunction

    // Reference model: push the output each edge will produce.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_sel <= 0; m_off <= 0; m_bcd <= 0; m_sign <= 0;
            sb_q.delete();
        end else begin
            sb_q.push_back(model_out(m_sel, m_off, m_bcd, m_sign));
            if (m_cnt == DIV - 1) begin
                m_cnt <= 0;
                m_sel <= m_sel + 2'd1;
            end else m_cnt <= m_cnt + 1;
            if (scroll_left && !scroll_right && m_off < 2) m_off <= m_off + 2'd1;
            if (scroll_right && !scroll_left && m_off > 0) m_off <= m_off - 2'd1;
            if (load) begin
                m_bcd <= bcd;
                m_sign <= sign;
            end
        end
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({an, seg} !== {4'b1111, S_BL}) $display("FAIL reset_hold got %b_%b exp 1111_1111111", an, seg);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) fr[i] = 'x;
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(negedge clk);
            n_total++;
            if (sb_q.size() == 0) $display("FAIL reset_sb empty at cycle %0d", cyc);
            else begin
                exp_v = sb_q.pop_front();
                if ({an, seg} !== exp_v) $display("FAIL reset_sb got %b_%b exp %b_%b", an, seg, exp_v[10:7], exp_v[6:0]);
                else n_pass++;
            end
            if (cyc == 0) begin
                n_total++;
                if ({an, seg} !== {4'b1110, glyph[0]}) $display("FAIL reset_first got %b_%b exp 1110_1000000", an, seg);
                else n_pass++;
            end
            case (an) 4'b1110: fr[0] = seg; 4'b1101: fr[1] = seg; 4'b1011: fr[2] = seg; 4'b0111: fr[3] = seg; default: ;
            endcase
        end
        want[0] = glyph[0]; want[1] = S_BL; want[2] = S_BL; want[3] = S_BL;
        for (int d = 0; d < 4; d++) begin
            n_total++;
            if (fr[d] !== want[d]) $display("FAIL reset_frame digit %0d got %b exp %b", d, fr[d], want[d]);
            else n_pass++;
        end
    endtask

    task automatic test_capture_scroll();
        // ops: 0 = load 01234 negative, 1 = left, 2 = right, 3 = both, 4 = idle
        int ops [8] = '{0, 1, 1, 1, 2, 2, 2, 2};
        for (int step = 0; step < 10; step++) begin
            if (step < 8) begin
                load = (ops[step] == 0); bcd = 20'h01234; sign = 1'b1;
                scroll_left = (ops[step] == 1 || ops[step] == 3);
                scroll_right = (ops[step] == 2 || ops[step] == 3);
            end
            if (step == 8) scroll_left = 1'b1;
            if (step == 9) begin scroll_left = 1'b1; scroll_right = 1'b1; end
            for (int i = 0; i < 4; i++) fr[i] = 'x;
            for (int cyc = 0; cyc < 17; cyc++) begin
                @(negedge clk);
                load = 1'b0; scroll_left = 1'b0; scroll_right = 1'b0;
                n_total++;
                if (sb_q.size() == 0) $display("FAIL scroll_sb empty at step %0d", step);
                else begin
                    exp_v = sb_q.pop_front();
                    if ({an, seg} !== exp_v) $display("FAIL scroll_sb step %0d got %b_%b exp %b_%b", step, an, seg, exp_v[10:7], exp_v[6:0]);
                    else n_pass++;
                end
                case (an) 4'b1110: fr[0] = seg; 4'b1101: fr[1] = seg; 4'b1011: fr[2] = seg; 4'b0111: fr[3] = seg; default: ;
                endcase
            end
            // offset 0 after load and after right-saturation, 2 after two/three lefts, 1 after left+both
            if (step == 0 || step == 7) begin
                want[0] = glyph[4]; want[1] = glyph[3]; want[2] = glyph[2]; want[3] = glyph[1];
            end else if (step == 2 || step == 3) begin
                want[0] = glyph[2]; want[1] = glyph[1]; want[2] = S_BL; want[3] = S_DA;
            end else if (step == 9) begin
                want[0] = glyph[3]; want[1] = glyph[2]; want[2] = glyph[1]; want[3] = S_BL;
            end else continue;
            for (int d = 0; d < 4; d++) begin
                n_total++;
                if (fr[d] !== want[d]) $display("FAIL scroll_frame step %0d digit %0d got %b exp %b", step, d, fr[d], want[d]);
                else n_pass++;
            end
        end
        scroll_right = 1'b1;
        @(negedge clk);
        scroll_right = 1'b0;
        n_total++;
        if (sb_q.size() == 0) $display("FAIL scroll_tail empty");
        else begin
            exp_v = sb_q.pop_front();
            if ({an, seg} !== exp_v) $display("FAIL scroll_tail got %b_%b exp %b_%b", an, seg, exp_v[10:7], exp_v[6:0]);
            else n_pass++;
        end
    endtask

    task automatic test_invalid_and_live();
        // pass 0: invalid units nibble; pass 1: load 00507 then live bcd changes without load
        for (int pass = 0; pass < 2; pass++) begin
            load = 1'b1; sign = 1'b0;
            bcd = (pass == 0) ? 20'h0000F : 20'h00507;
            for (int i = 0; i < 4; i++) fr[i] = 'x;
            for (int cyc = 0; cyc < 17; cyc++) begin
                @(negedge clk);
                load = 1'b0;
                bcd = 20'($urandom_range(0, 20'hFFFFF));
                sign = 1'($urandom_range(0, 1));
                n_total++;
                if (sb_q.size() == 0) $display("FAIL inv_live_sb empty pass %0d", pass);
                else begin
                    exp_v = sb_q.pop_front();
                    if ({an, seg} !== exp_v) $display("FAIL inv_live_sb pass %0d got %b_%b exp %b_%b", pass, an, seg, exp_v[10:7], exp_v[6:0]);
                    else n_pass++;
                end
                case (an) 4'b1110: fr[0] = seg; 4'b1101: fr[1] = seg; 4'b1011: fr[2] = seg; 4'b0111: fr[3] = seg; default: ;
                endcase
            end
            if (pass == 0) begin
                want[0] = S_BL; want[1] = S_BL; want[2] = S_BL; want[3] = S_BL;
            end else begin
                want[0] = glyph[7]; want[1] = glyph[0]; want[2] = glyph[5]; want[3] = S_BL;
            end
            for (int d = 0; d < 4; d++) begin
                n_total++;
                if (fr[d] !== want[d]) $display("FAIL inv_live_frame pass %0d digit %0d got %b exp %b", pass, d, fr[d], want[d]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        // load and scroll in the same cycle both take effect: offset 1 on 98765
        scroll_left = 1'b1; load = 1'b1; bcd = 20'h98765; sign = 1'b0;
        for (int i = 0; i < 4; i++) fr[i] = 'x;
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(negedge clk);
            load = 1'b0; scroll_left = 1'b0;
            n_total++;
            if (sb_q.size() == 0) $display("FAIL b2b_sb empty");
            else begin
                exp_v = sb_q.pop_front();
                if ({an, seg} !== exp_v) $display("FAIL b2b_sb got %b_%b exp %b_%b", an, seg, exp_v[10:7], exp_v[6:0]);
                else n_pass++;
            end
            case (an) 4'b1110: fr[0] = seg; 4'b1101: fr[1] = seg; 4'b1011: fr[2] = seg; 4'b0111: fr[3] = seg; default: ;
            endcase
        end
        want[0] = glyph[6]; want[1] = glyph[7]; want[2] = glyph[8]; want[3] = glyph[9];
        for (int d = 0; d < 4; d++) begin
            n_total++;
            if (fr[d] !== want[d]) $display("FAIL b2b_frame digit %0d got %b exp %b", d, fr[d], want[d]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        load = 1'b1; bcd = 20'h16384; sign = 1'b1;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            load = 1'b0;
            n_total++;
            if (sb_q.size() == 0) $display("FAIL arst_sb empty");
            else begin
                exp_v = sb_q.pop_front();
                if ({an, seg} !== exp_v) $display("FAIL arst_sb got %b_%b exp %b_%b", an, seg, exp_v[10:7], exp_v[6:0]);
                else n_pass++;
            end
            if (cyc > 0 && an == 4'b1011) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL arst_wait digit 2 never active, an=%b", an);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({an, seg} !== {4'b1111, S_BL}) $display("FAIL arst_immediate got %b_%b exp 1111_1111111", an, seg);
        else n_pass++;
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) fr[i] = 'x;
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(negedge clk);
            n_total++;
            if (sb_q.size() == 0) $display("FAIL arst_post_sb empty");
            else begin
                exp_v = sb_q.pop_front();
                if ({an, seg} !== exp_v) $display("FAIL arst_post_sb got %b_%b exp %b_%b", an, seg, exp_v[10:7], exp_v[6:0]);
                else n_pass++;
            end
            case (an) 4'b1110: fr[0] = seg; 4'b1101: fr[1] = seg; 4'b1011: fr[2] = seg; 4'b0111: fr[3] = seg; default: ;
            endcase
        end
        want[0] = glyph[0]; want[1] = S_BL; want[2] = S_BL; want[3] = S_BL;
        for (int d = 0; d < 4; d++) begin
            n_total++;
            if (fr[d] !== want[d]) $display("FAIL arst_frame digit %0d got %b exp %b", d, fr[d], want[d]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_capture_scroll();
        test_invalid_and_live();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
